// File: rtl/sdram_device_model.sv
// rtl/sdram_device_model.sv - cycle-based model of a 16-bit SDR SDRAM device
//
// Purpose:
//   Device side of the SDRAM interface. Decodes the command bus, keeps
//   per-bank open-row state and stores write data. It returns read data
//   CL cycles after the READ edge and latches the first protocol violation.
//   Burst length is fixed at 1. Only MROW_W row bits are stored, so higher
//   row bits alias.
//
// Optional feature:
//   SDRAM_MODEL_TIMING_CHK_EN - per-bank down-counters enforce T_RCD and T_RP.
//   A violating command is ignored and raises error code 6.
//
// Ports:
//   clk_i       in   SDRAM clock, rising edge
//   rst_i       in   synchronous active-high reset
//   cke_i       in   clock enable; low freezes decode, read pipe and outputs
//   cs_i        in   chip select, active low
//   ras_i       in   RAS, active low
//   cas_i       in   CAS, active low
//   we_i        in   WE, active low
//   bs_i        in   bank select
//   addr_i      in   row / column / mode; bit 10 = auto / all-precharge
//   dqml_i      in   low-byte mask, 1 = masked
//   dqmh_i      in   high-byte mask, 1 = masked
//   dq_i        in   write data
//   dq_o        out  read data
//   dq_oe_o     out  1 = model drives dq
//   err_o       out  sticky protocol-violation flag
//   err_code_o  out  code of the first violation, 0 = none
module sdram_device_model #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int BANK_W = 2,
  parameter int COL_W  = 9,
  parameter int MROW_W = 4,
  parameter int T_RCD  = 2,
  parameter int T_RP   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cke_i,
  input  logic              cs_i,
  input  logic              ras_i,
  input  logic              cas_i,
  input  logic              we_i,
  input  logic [BANK_W-1:0] bs_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              dqml_i,
  input  logic              dqmh_i,
  input  logic [DATA_W-1:0] dq_i,
  output logic [DATA_W-1:0] dq_o,
  output logic              dq_oe_o,
  output logic              err_o,
  output logic [2:0]        err_code_o
);

  localparam int NBANK  = 1 << BANK_W;
  localparam int AW     = BANK_W + MROW_W + COL_W;
  localparam int LANE_W = DATA_W / 2;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_t;

  logic [DATA_W-1:0] mem [1 << AW];
  logic [NBANK-1:0]  bank_active;
  logic [MROW_W-1:0] row_q [NBANK];
  logic              mode_loaded;
  logic [2:0]        cl_q;

  // Read pipe: entry 0 feeds the output register; a READ enters at CL-1.
  logic [2:0]        pipe_vld;
  logic [DATA_W-1:0] pipe_data [3];
  logic [1:0]        pipe_mask [3];

  cmd_t              cmd;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] out_word;
  logic              tm_busy;
  logic [2:0]        viol;
  logic              rd_issue;
  logic              rw_ok;
  logic              wr_do;
  logic              act_do;
  logic              pre_do;
  logic              lmr_do;

  logic unused_addr;
  assign unused_addr = ^addr_i;

`ifdef SDRAM_MODEL_TIMING_CHK_EN
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);
  logic [CNT_W-1:0] tcnt [NBANK];
`else
  logic unused_timing;
  assign unused_timing = (T_RCD + T_RP) > 0;
`endif

  always_comb begin
    cmd      = cmd_t'({ras_i, cas_i, we_i});
    idx      = {bs_i, row_q[bs_i], addr_i[COL_W-1:0]};
    rd_word  = mem[idx];
    out_word = {pipe_mask[0][1] ? {LANE_W{1'b0}} : pipe_data[0][DATA_W-1:LANE_W],
                pipe_mask[0][0] ? {LANE_W{1'b0}} : pipe_data[0][LANE_W-1:0]};
    tm_busy  = 1'b0;
`ifdef SDRAM_MODEL_TIMING_CHK_EN
    tm_busy  = (tcnt[bs_i] != '0);
`endif
    viol     = 3'd0;
    rd_issue = 1'b0;
    rw_ok    = 1'b0;
    wr_do    = 1'b0;
    act_do   = 1'b0;
    pre_do   = 1'b0;
    lmr_do   = 1'b0;
    if (cke_i && !cs_i) begin
      case (cmd)
        CMD_RD, CMD_WR: begin
          if (!mode_loaded)          viol = 3'd3;
          else if (!bank_active[bs_i]) viol = 3'd1;
          else if (tm_busy)          viol = 3'd6;
          rw_ok = (viol == 3'd0);
          // A READ to an idle bank is flagged but still returns data.
          if (cmd == CMD_RD) rd_issue = rw_ok || (viol == 3'd1);
          else               wr_do    = rw_ok;
        end
        CMD_ACT: begin
          if (bank_active[bs_i]) viol = 3'd2;
          else if (tm_busy)      viol = 3'd6;
          else                   act_do = 1'b1;
        end
        CMD_PRE: pre_do = 1'b1;
        CMD_REF: if (|bank_active) viol = 3'd4;
        CMD_LMR: begin
          if (|bank_active) viol = 3'd4;
          else if (addr_i[6:4] == 3'd2 || addr_i[6:4] == 3'd3) lmr_do = 1'b1;
          else viol = 3'd5;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_active <= '0;
      mode_loaded <= 1'b0;
      cl_q        <= 3'd2;
      pipe_vld    <= '0;
      dq_o        <= '0;
      dq_oe_o     <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= 3'd0;
`ifdef SDRAM_MODEL_TIMING_CHK_EN
      for (int b = 0; b < NBANK; b++) tcnt[b] <= '0;
`endif
    end else if (cke_i) begin
      dq_oe_o <= pipe_vld[0] && !(&pipe_mask[0]);
      dq_o    <= pipe_vld[0] ? out_word : '0;

      pipe_vld[0]  <= pipe_vld[1];
      pipe_data[0] <= pipe_data[1];
      pipe_mask[0] <= pipe_mask[1];
      if (rd_issue && cl_q == 3'd2) begin
        pipe_vld[1]  <= 1'b1;
        pipe_data[1] <= rd_word;
        pipe_mask[1] <= {dqmh_i, dqml_i};
      end else begin
        pipe_vld[1]  <= pipe_vld[2];
        pipe_data[1] <= pipe_data[2];
        pipe_mask[1] <= pipe_mask[2];
      end
      pipe_vld[2]  <= rd_issue && cl_q == 3'd3;
      pipe_data[2] <= rd_word;
      pipe_mask[2] <= {dqmh_i, dqml_i};

      if (viol != 3'd0) begin
        err_o <= 1'b1;
        if (!err_o) err_code_o <= viol;
      end

      if (lmr_do) begin
        cl_q        <= addr_i[6:4];
        mode_loaded <= 1'b1;
      end

`ifdef SDRAM_MODEL_TIMING_CHK_EN
      for (int b = 0; b < NBANK; b++)
        if (tcnt[b] != '0) tcnt[b] <= tcnt[b] - 1'b1;
`endif

      if (act_do) begin
        bank_active[bs_i] <= 1'b1;
        row_q[bs_i]       <= addr_i[MROW_W-1:0];
`ifdef SDRAM_MODEL_TIMING_CHK_EN
        tcnt[bs_i]        <= RCD_LD;
`endif
      end

      if (rw_ok && addr_i[10]) begin
        bank_active[bs_i] <= 1'b0;
`ifdef SDRAM_MODEL_TIMING_CHK_EN
        tcnt[bs_i]        <= RP_LD;
`endif
      end

      // Precharging an idle bank is a no-op and does not restart its counter.
      if (pre_do) begin
        for (int b = 0; b < NBANK; b++) begin
          if ((addr_i[10] || bs_i == BANK_W'(b)) && bank_active[b]) begin
            bank_active[b] <= 1'b0;
`ifdef SDRAM_MODEL_TIMING_CHK_EN
            tcnt[b]        <= RP_LD;
`endif
          end
        end
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_do) begin
      if (!dqml_i) mem[idx][LANE_W-1:0]      <= dq_i[LANE_W-1:0];
      if (!dqmh_i) mem[idx][DATA_W-1:LANE_W] <= dq_i[DATA_W-1:LANE_W];
    end
  end

endmodule

// File: tb/tb_sdram_device_model.sv
// tb/tb_sdram_device_model.sv - directed table-driven bench for sdram_device_model
module tb_sdram_device_model;

  localparam logic [2:0] LMR = 3'b000, PRE = 3'b010, ACT = 3'b011;
  localparam logic [2:0] WR = 3'b100, RD = 3'b101, NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst, cke, cs, ras, cas, we, dqml, dqmh;
  logic [1:0]  bs;
  logic [12:0] addr;
  logic [15:0] dq_in, dq_out;
  logic        dq_oe, err;
  logic [2:0]  err_code;

  int n_chk = 0;
  int n_err = 0;
  int vid   = 0;

  always #5 clk = ~clk;

  sdram_device_model dut (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .cs_i(cs), .ras_i(ras), .cas_i(cas),
    .we_i(we), .bs_i(bs), .addr_i(addr), .dqml_i(dqml), .dqmh_i(dqmh),
    .dq_i(dq_in), .dq_o(dq_out), .dq_oe_o(dq_oe), .err_o(err), .err_code_o(err_code)
  );

  // chk: 0 outputs not checked, 1 expect dq_oe=0, 2 expect dq_oe=1 and dq, 3 expect dq_oe=1 only
  typedef struct {
    logic        rst;
    logic        cke;
    logic [2:0]  cmd;
    logic [1:0]  bs;
    logic [12:0] addr;
    logic [1:0]  dqm;
    logic [15:0] dq;
    logic [1:0]  chk;
    logic [15:0] edq;
    logic [2:0]  code;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic ck, input logic [2:0] c,
                              input logic [1:0] b, input logic [12:0] a, input logic [1:0] m,
                              input logic [15:0] d, input logic [1:0] chk,
                              input logic [15:0] edq, input logic [2:0] code);
    vec_t v;
    v.rst = r; v.cke = ck; v.cmd = c; v.bs = b; v.addr = a; v.dqm = m; v.dq = d;
    v.chk = chk; v.edq = edq; v.code = code;
    return v;
  endfunction

  function automatic vec_t cv(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                              input logic [1:0] m, input logic [15:0] d, input logic [2:0] code);
    return mk(1'b0, 1'b1, c, b, a, m, d, 2'd1, 16'h0, code);
  endfunction

  function automatic vec_t nv(input logic [2:0] code);
    return cv(NOP, 2'd0, 13'h0, 2'b00, 16'h0, code);
  endfunction

  function automatic vec_t dv(input logic [15:0] edq, input logic [2:0] code);
    return mk(1'b0, 1'b1, NOP, 2'd0, 13'h0, 2'b00, 16'h0, 2'd2, edq, code);
  endfunction

  task automatic check(input string nm, input int id, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; cke = v.cke; cs = 1'b0; {ras, cas, we} = v.cmd;
    bs = v.bs; addr = v.addr; {dqmh, dqml} = v.dqm; dq_in = v.dq;
    @(posedge clk);
    #1;
    check("err_code", vid, {13'h0, err_code}, {13'h0, v.code});
    check("err", vid, {15'h0, err}, {15'h0, v.code != 3'd0});
    if (v.chk != 2'd0) check("dq_oe", vid, {15'h0, dq_oe}, {15'h0, v.chk != 2'd1});
    if (v.chk == 2'd2) check("dq", vid, dq_out, v.edq);
    vid++;
  endtask

  initial begin
    rst = 1'b1; cke = 1'b1; cs = 1'b1; ras = 1'b1; cas = 1'b1; we = 1'b1;
    bs = '0; addr = '0; dqml = 1'b0; dqmh = 1'b0; dq_in = '0;

    // Basic write / read at CL=2
    tbl.push_back(cv(LMR, 2'd0, 13'h020, 2'b00, 16'h0, 3'd0));
    tbl.push_back(cv(ACT, 2'd0, 13'h003, 2'b00, 16'h0, 3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(cv(WR,  2'd0, 13'h005, 2'b00, 16'hA5C3, 3'd0));
    tbl.push_back(cv(RD,  2'd0, 13'h005, 2'b00, 16'h0, 3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(dv(16'hA5C3, 3'd0));
    tbl.push_back(nv(3'd0));
    // CL=3 back-to-back reads
    tbl.push_back(cv(PRE, 2'd0, 13'h400, 2'b00, 16'h0, 3'd0));
    tbl.push_back(cv(LMR, 2'd0, 13'h030, 2'b00, 16'h0, 3'd0));
    tbl.push_back(cv(ACT, 2'd0, 13'h003, 2'b00, 16'h0, 3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(cv(WR,  2'd0, 13'h000, 2'b00, 16'h1111, 3'd0));
    tbl.push_back(cv(WR,  2'd0, 13'h001, 2'b00, 16'h2222, 3'd0));
    tbl.push_back(cv(WR,  2'd0, 13'h002, 2'b00, 16'h3333, 3'd0));
    tbl.push_back(cv(WR,  2'd0, 13'h003, 2'b00, 16'h4444, 3'd0));
    tbl.push_back(cv(RD,  2'd0, 13'h000, 2'b00, 16'h0, 3'd0));
    tbl.push_back(cv(RD,  2'd0, 13'h001, 2'b00, 16'h0, 3'd0));
    tbl.push_back(cv(RD,  2'd0, 13'h002, 2'b00, 16'h0, 3'd0));
    tbl.push_back(mk(1'b0, 1'b1, RD, 2'd0, 13'h003, 2'b00, 16'h0, 2'd2, 16'h1111, 3'd0));
    tbl.push_back(dv(16'h2222, 3'd0));
    tbl.push_back(dv(16'h3333, 3'd0));
    tbl.push_back(dv(16'h4444, 3'd0));
    tbl.push_back(nv(3'd0));
    // Byte masks on write and read
    tbl.push_back(cv(WR,  2'd0, 13'h007, 2'b00, 16'hFFFF, 3'd0));
    tbl.push_back(cv(WR,  2'd0, 13'h007, 2'b10, 16'h1234, 3'd0));
    tbl.push_back(cv(RD,  2'd0, 13'h007, 2'b00, 16'h0, 3'd0));
    tbl.push_back(cv(RD,  2'd0, 13'h007, 2'b11, 16'h0, 3'd0));
    tbl.push_back(cv(RD,  2'd0, 13'h007, 2'b01, 16'h0, 3'd0));
    tbl.push_back(dv(16'hFF34, 3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(dv(16'hFF00, 3'd0));
    tbl.push_back(nv(3'd0));
    // Write behind a pending read
    tbl.push_back(cv(RD,  2'd0, 13'h007, 2'b00, 16'h0, 3'd0));
    tbl.push_back(cv(WR,  2'd0, 13'h007, 2'b00, 16'h0000, 3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(dv(16'hFF34, 3'd0));
    tbl.push_back(cv(RD,  2'd0, 13'h007, 2'b00, 16'h0, 3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(dv(16'h0000, 3'd0));
    // Row aliasing
    tbl.push_back(cv(PRE, 2'd0, 13'h400, 2'b00, 16'h0, 3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(cv(ACT, 2'd1, 13'h013, 2'b00, 16'h0, 3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(cv(WR,  2'd1, 13'h009, 2'b00, 16'hBEEF, 3'd0));
    tbl.push_back(cv(PRE, 2'd0, 13'h400, 2'b00, 16'h0, 3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(cv(ACT, 2'd1, 13'h003, 2'b00, 16'h0, 3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(cv(RD,  2'd1, 13'h009, 2'b00, 16'h0, 3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(dv(16'hBEEF, 3'd0));
    // Write with auto-precharge lets the bank be re-activated
    tbl.push_back(cv(WR,  2'd1, 13'h409, 2'b00, 16'h0BAD, 3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(cv(ACT, 2'd1, 13'h003, 2'b00, 16'h0, 3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(cv(RD,  2'd1, 13'h009, 2'b00, 16'h0, 3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(nv(3'd0));
    tbl.push_back(dv(16'h0BAD, 3'd0));
    tbl.push_back(nv(3'd0));
    // Errors: READ to idle bank 2 still returns data; later violations keep code 1
    tbl.push_back(cv(RD,  2'd2, 13'h000, 2'b00, 16'h0, 3'd1));
    tbl.push_back(nv(3'd1));
    tbl.push_back(nv(3'd1));
    tbl.push_back(mk(1'b0, 1'b1, NOP, 2'd0, 13'h0, 2'b00, 16'h0, 2'd3, 16'h0, 3'd1));
    tbl.push_back(cv(ACT, 2'd1, 13'h003, 2'b00, 16'h0, 3'd1));
    tbl.push_back(cv(LMR, 2'd0, 13'h070, 2'b00, 16'h0, 3'd1));
    tbl.push_back(nv(3'd1));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst dq", -1, dq_out, 16'h0);
    check("rst dq_oe", -1, {15'h0, dq_oe}, 16'h0);
    check("rst err", -1, {15'h0, err}, 16'h0);
    check("rst err_code", -1, {13'h0, err_code}, 16'h0);

    foreach (tbl[i]) apply(tbl[i]);

    // Reset with a read in flight: no output pulse afterwards
    apply(mk(1'b0, 1'b1, RD, 2'd1, 13'h009, 2'b00, 16'h0, 2'd0, 16'h0, 3'd1));
    apply(mk(1'b1, 1'b1, NOP, 2'd0, 13'h0, 2'b00, 16'h0, 2'd1, 16'h0, 3'd0));
    check("rst2 dq", vid, dq_out, 16'h0);
    repeat (4) apply(nv(3'd0));

    // cke low: pipe frozen, commands suppressed, outputs held
    apply(cv(LMR, 2'd0, 13'h020, 2'b00, 16'h0, 3'd0));
    apply(cv(ACT, 2'd0, 13'h003, 2'b00, 16'h0, 3'd0));
    apply(nv(3'd0));
    apply(cv(RD,  2'd0, 13'h005, 2'b00, 16'h0, 3'd0));
    apply(mk(1'b0, 1'b0, WR, 2'd0, 13'h005, 2'b00, 16'h0000, 2'd1, 16'h0, 3'd0));
    apply(mk(1'b0, 1'b0, NOP, 2'd0, 13'h0, 2'b00, 16'h0, 2'd1, 16'h0, 3'd0));
    apply(nv(3'd0));
    apply(dv(16'hA5C3, 3'd0));
    apply(nv(3'd0));
    apply(cv(RD,  2'd0, 13'h005, 2'b00, 16'h0, 3'd0));
    apply(nv(3'd0));
    apply(dv(16'hA5C3, 3'd0));
    apply(mk(1'b0, 1'b0, NOP, 2'd0, 13'h0, 2'b00, 16'h0, 2'd2, 16'hA5C3, 3'd0));
    apply(nv(3'd0));

    // READ one cycle after ACTIVE
    apply(cv(PRE, 2'd0, 13'h000, 2'b00, 16'h0, 3'd0));
    apply(nv(3'd0));
    apply(cv(ACT, 2'd0, 13'h003, 2'b00, 16'h0, 3'd0));
`ifdef SDRAM_MODEL_TIMING_CHK_EN
    apply(cv(RD, 2'd0, 13'h005, 2'b00, 16'h0, 3'd6));
    apply(nv(3'd6));
    apply(nv(3'd6));
    apply(nv(3'd6));
`else
    apply(cv(RD, 2'd0, 13'h005, 2'b00, 16'h0, 3'd0));
    apply(nv(3'd0));
    apply(dv(16'hA5C3, 3'd0));
    apply(nv(3'd0));
`endif

    // WRITE before any LOAD MODE to an active bank
    apply(mk(1'b1, 1'b1, NOP, 2'd0, 13'h0, 2'b00, 16'h0, 2'd1, 16'h0, 3'd0));
    apply(cv(ACT, 2'd0, 13'h003, 2'b00, 16'h0, 3'd0));
    apply(nv(3'd0));
    apply(cv(WR,  2'd0, 13'h005, 2'b00, 16'h0, 3'd3));
    apply(nv(3'd3));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
